bar_conditioner: RTL and testbench
==================================

BAR_CONDITIONER -- requirements
Module: bar_conditioner

Interface
REQ-001 SHALL have parameter NUM_BARS, default 16, number of spectrum bars.
REQ-002 SHALL have parameter IN_W, default 18, signed sample width.
REQ-003 SHALL have parameter H_W, default 9, bar/peak height width in pixels.
REQ-004 SHALL have parameter SCALE_SHIFT, default 8, right shift from magnitude to pixels.
REQ-005 SHALL have parameter MAX_H, default 400, height clamp.
REQ-006 SHALL have parameter DECAY_SHIFT, default 3, fall-rate shift.
REQ-007 SHALL have parameter HOLD_FRAMES, default 30, peak hold duration in frames.
REQ-008 SHALL have port clk_25 input 1, 25 MHz pixel-domain clock.
REQ-009 SHALL have port rst input 1, reset: synchronous, active-high.
REQ-010 SHALL have port start input 1, one-cycle pulse, new frame of samples available.
REQ-011 SHALL have port samples input [IN_W-1:0] x NUM_BARS, two's-complement per-bar samples.
REQ-012 SHALL have port busy output 1, high while a frame is being processed.
REQ-013 SHALL have port done output 1, one-cycle pulse when outputs update.
REQ-014 SHALL have port heights output [H_W-1:0] x NUM_BARS, smoothed bar heights to the VGA stage.
REQ-015 SHALL have port peaks output [H_W-1:0] x NUM_BARS, peak-hold markers to the VGA stage.

Function
REQ-016 SHALL implement states IDLE, PROC, COMMIT; busy SHALL be high exactly in PROC and COMMIT.
REQ-017 In IDLE, start=1 at edge E0 SHALL snapshot all samples into internal registers, set idx=0, enter PROC.
REQ-018 start SHALL be ignored while busy; later changes on samples SHALL not affect the frame in progress.
REQ-019 PROC SHALL process bar idx at each edge E1..E16 (one bar per cycle), then enter COMMIT after idx=NUM_BARS-1.
REQ-020 Magnitude SHALL be |sample|; most-negative value (-2^(IN_W-1)) SHALL saturate to 2^(IN_W-1)-1.
REQ-021 target SHALL be min(magnitude >> SCALE_SHIFT, MAX_H).
REQ-022 If target >= height, new height SHALL be target.
REQ-023 Otherwise new height SHALL be height - max(1, (height-target) >> DECAY_SHIFT), never below target.
REQ-024 If new height >= peak: peak SHALL be new height, hold counter SHALL load HOLD_FRAMES.
REQ-025 Else if hold counter > 0: peak SHALL hold, counter SHALL decrement by 1.
REQ-026 Else peak SHALL be max(peak-1, new height).
REQ-027 Results SHALL go to working registers; outputs SHALL not change during PROC.
REQ-028 At COMMIT edge (E17), heights and peaks SHALL load all working values in one cycle; done SHALL be 1 for exactly that following cycle; state SHALL return to IDLE.
REQ-029 Start-to-output latency SHALL be NUM_BARS+1 clocks; a start in the cycle after done SHALL be accepted.
REQ-030 All arithmetic SHALL be unsigned at H_W bits after magnitude; no wrap-around on height or peak.

Reset
REQ-031 rst=1 SHALL, at any state including mid-PROC, force IDLE, idx=0, busy=0, done=0, all heights, peaks, working registers and hold counters to 0.
REQ-032 A frame aborted by reset SHALL produce no done pulse and no output update; rst SHALL take priority over start in the same cycle.

Verification
REQ-033 Reset, then start with all samples=65536 -> busy high 17 cycles, done pulse at E17, all heights=256, peaks=256.
REQ-034 sample[3]=-65536, sample[5]=-131072, sample[7]=131071, others 0 -> heights[3]=256, heights[5]=400, heights[7]=400, others 0.
REQ-035 Heights 256, then frame of zeros -> heights 224; frame of zeros from height 5 -> 4; repeated zero frames reach 0 and stay 0.
REQ-036 Peak 256 then zero frames -> peaks stay 256 for 30 frames, then 255, 254, ...; never below heights.
REQ-037 Start pulses at E5 and E10 during PROC -> ignored, single done at E17; rst at E8 -> no done, all outputs 0, next start behaves as fresh.

Source files
------------

// File: rtl/bar_conditioner.sv
// Spectrum bar conditioner for the VGA stage.
// A frame of signed per-bar samples is snapshotted on start. Bars are then
// processed one per clock into working registers: magnitude, scale, clamp,
// smoothed fall and peak-hold. All bars are published together on commit.
module bar_conditioner #(
  parameter int NUM_BARS    = 16,
  parameter int IN_W        = 18,
  parameter int H_W         = 9,
  parameter int SCALE_SHIFT = 8,
  parameter int MAX_H       = 400,
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 30
) (
  input  logic            clk_25,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] samples [NUM_BARS],
  output logic            busy,
  output logic            done,
  output logic [H_W-1:0]  heights [NUM_BARS],
  output logic [H_W-1:0]  peaks   [NUM_BARS]
);

  localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int HC_W  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [IN_W-1:0] MOST_NEG  = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] MAX_MAG   = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MAX_H_IN  = IN_W'(MAX_H);
  localparam logic [H_W-1:0]  MAX_H_H   = H_W'(MAX_H);
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLD_FRAMES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARS - 1);

  typedef enum logic [1:0] {IDLE, PROC, COMMIT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IN_W-1:0]  snap     [NUM_BARS];
  logic [H_W-1:0]   work_h   [NUM_BARS];
  logic [H_W-1:0]   work_p   [NUM_BARS];
  logic [HC_W-1:0]  hold_cnt [NUM_BARS];

  logic [IN_W-1:0] cur_sample;
  logic [IN_W-1:0] mag;
  logic [IN_W-1:0] scaled;
  logic [H_W-1:0]  target;
  logic [H_W-1:0]  cur_h;
  logic [H_W-1:0]  cur_p;
  logic [H_W-1:0]  diff;
  logic [H_W-1:0]  step;
  logic [H_W-1:0]  new_h;
  logic [H_W-1:0]  new_p;
  logic [HC_W-1:0] cur_hold;
  logic [HC_W-1:0] new_hold;

  // Per-bar update for the bar currently selected by idx
  always_comb begin
    cur_sample = snap[idx];
    cur_h      = work_h[idx];
    cur_p      = work_p[idx];
    cur_hold   = hold_cnt[idx];
    mag        = cur_sample;
    scaled     = '0;
    target     = '0;
    diff       = '0;
    step       = '0;
    new_h      = cur_h;
    new_p      = cur_p;
    new_hold   = cur_hold;

    if (cur_sample[IN_W-1]) begin
      if (cur_sample == MOST_NEG) mag = MAX_MAG;
      else                        mag = -cur_sample;
    end

    scaled = mag >> SCALE_SHIFT;
    if (scaled > MAX_H_IN) target = MAX_H_H;
    else                   target = H_W'(scaled);

    if (target >= cur_h) begin
      new_h = target;
    end else begin
      diff = cur_h - target;
      step = diff >> DECAY_SHIFT;
      if (step == '0) step = H_W'(1);
      if (diff <= step) new_h = target;
      else              new_h = cur_h - step;
    end

    if (new_h >= cur_p) begin
      new_p    = new_h;
      new_hold = HOLD_INIT;
    end else if (cur_hold != '0) begin
      new_p    = cur_p;
      new_hold = cur_hold - HC_W'(1);
    end else begin
      if ((cur_p - H_W'(1)) > new_h) new_p = cur_p - H_W'(1);
      else                           new_p = new_h;
      new_hold = '0;
    end
  end

  // Frame sequencer: snapshot, walk the bars, then publish everything at once
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NUM_BARS; i++) begin
        snap[i]     <= '0;
        work_h[i]   <= '0;
        work_p[i]   <= '0;
        hold_cnt[i] <= '0;
        heights[i]  <= '0;
        peaks[i]    <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_BARS; i++) snap[i] <= samples[i];
            idx   <= '0;
            busy  <= 1'b1;
            state <= PROC;
          end
        end
        PROC: begin
          work_h[idx]   <= new_h;
          work_p[idx]   <= new_p;
          hold_cnt[idx] <= new_hold;
          if (idx == LAST_IDX) state <= COMMIT;
          else                 idx   <= idx + IDX_W'(1);
        end
        COMMIT: begin
          for (int i = 0; i < NUM_BARS; i++) begin
            heights[i] <= work_h[i];
            peaks[i]   <= work_p[i];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bar_conditioner.sv
// Self-checking bench for bar_conditioner: directed frames from the
// requirements plus random frames, all checked against a frame-level model.
module tb_bar_conditioner;

  localparam int NB      = 16;
  localparam int IN_W    = 18;
  localparam int H_W     = 9;
  localparam int MAX_MAG = 2**(IN_W-1) - 1;

  typedef logic [IN_W-1:0] frame_t [NB];
  typedef logic [H_W-1:0]  hvec_t  [NB];

  logic   clk_25 = 1'b0;
  logic   rst;
  logic   start;
  frame_t samples;
  logic   busy;
  logic   done;
  hvec_t  heights;
  hvec_t  peaks;

  int total = 0;
  int bad   = 0;

  int m_h[NB];
  int m_p[NB];
  int m_hold[NB];

  int obs_busy;
  int obs_done_cyc;
  int obs_done_cnt;
  bit obs_early;

  bar_conditioner #(
    .NUM_BARS(NB), .IN_W(IN_W), .H_W(H_W), .SCALE_SHIFT(8),
    .MAX_H(400), .DECAY_SHIFT(3), .HOLD_FRAMES(30)
  ) dut (
    .clk_25(clk_25), .rst(rst), .start(start), .samples(samples),
    .busy(busy), .done(done), .heights(heights), .peaks(peaks)
  );

  // 25 MHz pixel clock
  always #20 clk_25 = ~clk_25;

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_h[i] = 0; m_p[i] = 0; m_hold[i] = 0;
    end
  endfunction

  // One whole frame, computed from the rules with plain integer arithmetic
  function automatic void model_frame(input frame_t s);
    int v, mag, tgt, nh, d;
    for (int i = 0; i < NB; i++) begin
      v = $signed(s[i]);
      mag = (v < 0) ? -v : v;
      if (mag > MAX_MAG) mag = MAX_MAG;
      tgt = mag / 256;
      if (tgt > 400) tgt = 400;
      if (tgt >= m_h[i]) nh = tgt;
      else begin
        d = (m_h[i] - tgt) / 8;
        if (d < 1) d = 1;
        nh = m_h[i] - d;
        if (nh < tgt) nh = tgt;
      end
      m_h[i] = nh;
      if (nh >= m_p[i]) begin
        m_p[i] = nh; m_hold[i] = 30;
      end else if (m_hold[i] > 0) begin
        m_hold[i] = m_hold[i] - 1;
      end else begin
        m_p[i] = (m_p[i] - 1 > nh) ? m_p[i] - 1 : nh;
      end
    end
  endfunction

  function automatic frame_t fill(input int val);
    frame_t f;
    for (int i = 0; i < NB; i++) f[i] = IN_W'(val);
    return f;
  endfunction

  task automatic doReset();
    rst = 1'b1; start = 1'b0;
    @(negedge clk_25); @(negedge clk_25);
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one frame; scrambles samples while busy; optional extra start
  // pulses and a mid-frame reset at given cycle offsets after E0
  task automatic applyStimulus(input frame_t s, input int st_a, input int st_b,
                               input int rst_at, input int cycles);
    hvec_t pre_h, pre_p;
    pre_h = heights; pre_p = peaks;
    samples = s; start = 1'b1;
    @(posedge clk_25);
    obs_busy = 0; obs_done_cyc = -1; obs_done_cnt = 0; obs_early = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_25);
      start = 1'b0; rst = 1'b0;
      if (busy === 1'b1) obs_busy++;
      if (done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) obs_done_cyc = c;
      end
      if (obs_done_cyc < 0 && (rst_at < 0 || c <= rst_at))
        for (int i = 0; i < NB; i++)
          if (heights[i] !== pre_h[i] || peaks[i] !== pre_p[i]) obs_early = 1'b1;
      for (int i = 0; i < NB; i++) samples[i] = IN_W'($urandom);
      if (c == st_a || c == st_b) start = 1'b1;
      if (c == rst_at) rst = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; samples = fill(65536);
    repeat (3) @(negedge clk_25);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (heights[i] !== '0 || peaks[i] !== '0) begin
        bad++; $display("[TB] FAIL reset_out bar%0d got h=%0d p=%0d want 0", i, heights[i], peaks[i]);
      end
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk_25);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_vs_start busy got=%b want=0", busy); end
    model_reset();
  endtask

  task automatic test_uniform();
    frame_t f;
    f = fill(65536);
    applyStimulus(f, -1, -1, -1, 20);
    model_frame(f);
    total++; if (obs_busy != 17) begin bad++; $display("[TB] FAIL uni_busy got=%0d want=17", obs_busy); end
    total++; if (obs_done_cyc != 17) begin bad++; $display("[TB] FAIL uni_latency got=%0d want=17", obs_done_cyc); end
    total++; if (obs_done_cnt != 1) begin bad++; $display("[TB] FAIL uni_done_cnt got=%0d want=1", obs_done_cnt); end
    total++; if (obs_early) begin bad++; $display("[TB] FAIL uni_early got=1 want=0"); end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (heights[i] !== 9'd256 || peaks[i] !== 9'd256 || int'(heights[i]) != m_h[i]) begin
        bad++; $display("[TB] FAIL uni_out bar%0d got h=%0d p=%0d want 256", i, heights[i], peaks[i]);
      end
    end
  endtask

  task automatic test_signed_mix();
    frame_t f;
    int want;
    doReset();
    f = fill(0);
    f[3] = IN_W'(-65536); f[5] = IN_W'(-131072); f[7] = IN_W'(131071);
    applyStimulus(f, -1, -1, -1, 20);
    model_frame(f);
    for (int i = 0; i < NB; i++) begin
      want = (i == 3) ? 256 : (i == 5 || i == 7) ? 400 : 0;
      total++;
      if (int'(heights[i]) != want || int'(heights[i]) != m_h[i] || int'(peaks[i]) != m_p[i]) begin
        bad++; $display("[TB] FAIL mix bar%0d got h=%0d p=%0d want h=%0d p=%0d", i, heights[i], peaks[i], want, m_p[i]);
      end
    end
  endtask

  task automatic test_decay();
    frame_t z;
    z = fill(0);
    doReset();
    applyStimulus(fill(65536), -1, -1, -1, 20); model_frame(fill(65536));
    applyStimulus(z, -1, -1, -1, 20); model_frame(z);
    for (int i = 0; i < NB; i++) begin
      total++;
      if (heights[i] !== 9'd224 || int'(peaks[i]) != m_p[i]) begin
        bad++; $display("[TB] FAIL decay224 bar%0d got=%0d want=224", i, heights[i]);
      end
    end
    doReset();
    applyStimulus(fill(1280), -1, -1, -1, 20); model_frame(fill(1280));
    applyStimulus(z, -1, -1, -1, 20); model_frame(z);
    total++; if (heights[0] !== 9'd4) begin bad++; $display("[TB] FAIL decay_min_step got=%0d want=4", heights[0]); end
    repeat (6) begin applyStimulus(z, -1, -1, -1, 20); model_frame(z); end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (heights[i] !== '0 || int'(peaks[i]) != m_p[i]) begin
        bad++; $display("[TB] FAIL decay_floor bar%0d got h=%0d p=%0d want h=0 p=%0d", i, heights[i], peaks[i], m_p[i]);
      end
    end
  endtask

  task automatic test_peak_hold();
    frame_t z;
    int want;
    z = fill(0);
    doReset();
    applyStimulus(fill(65536), -1, -1, -1, 20); model_frame(fill(65536));
    for (int k = 1; k <= 45; k++) begin
      applyStimulus(z, -1, -1, -1, 20); model_frame(z);
      want = (k <= 30) ? 256 : 256 - (k - 30);
      total++;
      if (int'(peaks[2]) != want || int'(peaks[2]) != m_p[2] || int'(heights[2]) != m_h[2]
          || peaks[2] < heights[2]) begin
        bad++; $display("[TB] FAIL peak_hold frame%0d got p=%0d h=%0d want p=%0d h=%0d", k, peaks[2], heights[2], want, m_h[2]);
      end
    end
  endtask

  task automatic test_ignore_and_abort();
    frame_t f;
    doReset();
    for (int i = 0; i < NB; i++) f[i] = IN_W'($urandom);
    applyStimulus(f, 4, 9, -1, 20); model_frame(f);
    total++; if (obs_done_cnt != 1 || obs_done_cyc != 17) begin
      bad++; $display("[TB] FAIL ignore_start got done_cnt=%0d at=%0d want 1 at 17", obs_done_cnt, obs_done_cyc); end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (int'(heights[i]) != m_h[i] || int'(peaks[i]) != m_p[i]) begin
        bad++; $display("[TB] FAIL ignore_out bar%0d got h=%0d p=%0d want h=%0d p=%0d", i, heights[i], peaks[i], m_h[i], m_p[i]);
      end
    end
    for (int i = 0; i < NB; i++) f[i] = IN_W'($urandom);
    applyStimulus(f, -1, -1, 7, 20); model_reset();
    total++; if (obs_done_cnt != 0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL abort got done_cnt=%0d busy=%b want 0 0", obs_done_cnt, busy); end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (heights[i] !== '0 || peaks[i] !== '0) begin
        bad++; $display("[TB] FAIL abort_out bar%0d got h=%0d p=%0d want 0", i, heights[i], peaks[i]);
      end
    end
    f = fill(-40000);
    applyStimulus(f, -1, -1, -1, 20); model_frame(f);
    total++; if (obs_done_cyc != 17 || int'(heights[9]) != m_h[9] || int'(peaks[9]) != m_p[9]) begin
      bad++; $display("[TB] FAIL fresh_after_abort got at=%0d h=%0d want at=17 h=%0d", obs_done_cyc, heights[9], m_h[9]); end
  endtask

  task automatic test_back_to_back();
    frame_t f;
    int lens[3] = '{18, 19, 20};
    doReset();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NB; i++) f[i] = IN_W'($urandom);
      applyStimulus(f, -1, -1, -1, lens[n]); model_frame(f);
      total++; if (obs_done_cyc != 17 || obs_done_cnt != 1) begin
        bad++; $display("[TB] FAIL b2b frame%0d got at=%0d cnt=%0d want 17 1", n, obs_done_cyc, obs_done_cnt); end
      for (int i = 0; i < NB; i++) begin
        total++;
        if (int'(heights[i]) != m_h[i] || int'(peaks[i]) != m_p[i]) begin
          bad++; $display("[TB] FAIL b2b_out frame%0d bar%0d got h=%0d p=%0d want h=%0d p=%0d", n, i, heights[i], peaks[i], m_h[i], m_p[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    frame_t f;
    int sel, v;
    doReset();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NB; i++) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0: v = $urandom;
          1: v = $urandom_range(0, 8191);
          2: v = -$urandom_range(0, 8191);
          3: v = -(MAX_MAG + 1);
          default: v = 0;
        endcase
        f[i] = IN_W'(v);
      end
      applyStimulus(f, -1, -1, -1, 20); model_frame(f);
      total++; if (obs_done_cyc != 17 || obs_busy != 17 || obs_early) begin
        bad++; $display("[TB] FAIL rnd_timing frame%0d got at=%0d busy=%0d early=%0b want 17 17 0", n, obs_done_cyc, obs_busy, obs_early); end
      for (int i = 0; i < NB; i++) begin
        total++;
        if (int'(heights[i]) != m_h[i] || int'(peaks[i]) != m_p[i]) begin
          bad++; $display("[TB] FAIL rnd_out frame%0d bar%0d got h=%0d p=%0d want h=%0d p=%0d", n, i, heights[i], peaks[i], m_h[i], m_p[i]);
        end
      end
    end
  endtask

  // Scenario sequence
  initial begin
    rst = 1'b1; start = 1'b0; samples = fill(0);
    test_reset();
    test_uniform();
    test_signed_mix();
    test_decay();
    test_peak_hold();
    test_ignore_and_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
